// File: rtl/conv1_frame_ctrl.sv
// conv1_frame_ctrl: frame sequencer for the first convolution stage.
// Clears conv1, streams one WIDTH x HEIGHT binary image and counts outputs.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   start          frame request, honoured in IDLE only
//   abort          synchronous abort of the running frame
//   mem_addr       image memory read address (row-major)
//   mem_rd         image memory read enable
//   mem_rdata      pixel data, valid one cycle after mem_rd
//   conv_rst_n     registered active-low clear towards conv1
//   pixel_out      serial pixel towards conv1
//   conv_valid     conv1 output-valid strobe
//   busy           frame in progress
//   done           one-cycle frame completion pulse
//   out_count      conv1 outputs seen in the current frame
//   err            sticky drain watchdog error
//
// Optional feature: define CONV1_CTRL_WDT_EN to build the drain watchdog
// (DRAIN_MAX cycles). Without it err is tied low and DRAIN waits forever.

module conv1_frame_ctrl #(
    parameter int WIDTH      = 28,
    parameter int HEIGHT     = 28,
    parameter int CLR_CYCLES = 4,
    parameter int DRAIN_MAX  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [9:0] mem_addr,
    output logic       mem_rd,
    input  logic       mem_rdata,
    output logic       conv_rst_n,
    output logic       pixel_out,
    input  logic       conv_valid,
    output logic       busy,
    output logic       done,
    output logic [9:0] out_count,
    output logic       err
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int NOUT = (WIDTH - 2) * (HEIGHT - 2);

    localparam logic [9:0] LAST_ADDR = 10'(NPIX - 1);
    localparam logic [9:0] OUT_FULL  = 10'(NOUT);
    localparam logic [9:0] OUT_LAST  = 10'(NOUT - 1);

    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

    // An illegal configuration never leaves IDLE rather than
    // streaming with wrapped addresses or counters.
    localparam bit CFG_OK = (CLR_CYCLES >= 1) &&
                            (DRAIN_MAX >= 1) &&
                            (WIDTH >= 3) &&
                            (HEIGHT >= 3) &&
                            (NPIX <= 1024);

`ifdef CONV1_CTRL_WDT_EN
    localparam int DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_clr_cnt;
    logic [9:0]      r_mem_addr;
    logic            r_mem_rd;
    logic            r_pix_vld;
    logic            r_conv_rst_n;
    logic            r_busy;
    logic            r_done;
    logic [9:0]      r_out_count;
`ifdef CONV1_CTRL_WDT_EN
    logic [DW-1:0]   r_drain_cnt;
    logic            r_err;
`endif

    logic w_counting;
    logic w_count_en;
    logic w_out_hit;

    // conv_valid only matters while pixels are (or were just) in flight.
    assign w_counting = (r_state == S_STREAM) ||
                        (r_state == S_DRAIN);

    assign w_count_en = w_counting &&
                        conv_valid &&
                        (r_out_count != OUT_FULL);

    // Completion also fires in the cycle the final valid arrives.
    assign w_out_hit = (r_out_count == OUT_FULL) ||
                       (conv_valid && (r_out_count == OUT_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_clr_cnt    <= '0;
            r_mem_addr   <= '0;
            r_mem_rd     <= 1'b0;
            r_pix_vld    <= 1'b0;
            r_conv_rst_n <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_out_count  <= '0;
`ifdef CONV1_CTRL_WDT_EN
            r_drain_cnt  <= '0;
            r_err        <= 1'b0;
`endif
        end else if (abort && r_busy) begin
            // One-cycle conv1 clear flushes any partial window state.
            r_state      <= S_IDLE;
            r_mem_addr   <= '0;
            r_mem_rd     <= 1'b0;
            r_pix_vld    <= 1'b0;
            r_conv_rst_n <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_pix_vld <= r_mem_rd;
            r_done    <= 1'b0;

            if (w_count_en) begin
                r_out_count <= r_out_count + 10'd1;
            end

            unique case (r_state)
                S_IDLE: begin
                    r_conv_rst_n <= 1'b1;
                    if (start && CFG_OK) begin
                        r_state      <= S_CLEAR;
                        r_clr_cnt    <= '0;
                        r_conv_rst_n <= 1'b0;
                        r_busy       <= 1'b1;
                        r_out_count  <= '0;
`ifdef CONV1_CTRL_WDT_EN
                        r_err        <= 1'b0;
`endif
                    end
                end

                S_CLEAR: begin
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state      <= S_STREAM;
                        r_conv_rst_n <= 1'b1;
                        r_mem_rd     <= 1'b1;
                        r_mem_addr   <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end

                S_STREAM: begin
                    if (r_mem_addr == LAST_ADDR) begin
                        r_state    <= S_DRAIN;
                        r_mem_rd   <= 1'b0;
                        r_mem_addr <= '0;
`ifdef CONV1_CTRL_WDT_EN
                        r_drain_cnt <= '0;
`endif
                    end else begin
                        r_mem_addr <= r_mem_addr + 10'd1;
                    end
                end

                S_DRAIN: begin
                    if (w_out_hit) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
`ifdef CONV1_CTRL_WDT_EN
                    else if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
`endif
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Data returns one cycle after the read, so the delayed read
    // strobe gates it; garbage on mem_rdata never reaches conv1.
    assign pixel_out  = r_pix_vld & mem_rdata;

    assign mem_addr   = r_mem_addr;
    assign mem_rd     = r_mem_rd;
    assign conv_rst_n = r_conv_rst_n;
    assign busy       = r_busy;
    assign done       = r_done;
    assign out_count  = r_out_count;

`ifdef CONV1_CTRL_WDT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// tb_conv1_frame_ctrl: randomized bench for conv1_frame_ctrl.
// Expected outputs come from a frame-timeline model (cycle offsets).

module tb_conv1_frame_ctrl;

    localparam int W     = 28;
    localparam int H     = 28;
    localparam int CLR   = 4;
    localparam int DMAX  = 64;
    localparam int N     = W * H;
    localparam int TOTAL = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       mem_rdata = 1'b0;
    logic       conv_valid = 1'b0;
    logic [9:0] mem_addr;
    logic       mem_rd;
    logic       conv_rst_n;
    logic       pixel_out;
    logic       busy;
    logic       done;
    logic [9:0] out_count;
    logic       err;

    always #5 clk = ~clk;

    conv1_frame_ctrl #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .CLR_CYCLES (CLR),
        .DRAIN_MAX  (DMAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .conv_rst_n (conv_rst_n),
        .pixel_out  (pixel_out),
        .conv_valid (conv_valid),
        .busy       (busy),
        .done       (done),
        .out_count  (out_count),
        .err        (err)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: frame accepted into cycle m_t0; phase = cycle - m_t0.
    int t = 0;
    bit m_in = 1'b0;
    bit m_flush = 1'b1;
    bit m_done = 1'b0;
    bit m_err = 1'b0;
    int m_t0 = 0;
    int m_cnt = 0;
    int m_issued = 0;
    int mode = 0;
    bit img [0:1023];
    bit rd_q = 1'b0;
    int addr_q = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d",
                     tag, t, got, exp);
        end
    endtask

    // Advance the model across one clock edge using the sampled inputs.
    function automatic void model_edge();
        bit was_done;
        int d;
        was_done = m_done;
        m_done = 1'b0;
        m_flush = 1'b0;
        if (m_in) begin
            d = t - m_t0;
            if (abort) begin
                m_in = 1'b0;
                m_flush = 1'b1;
            end else begin
                if (d >= CLR && conv_valid && m_cnt < TOTAL)
                    m_cnt++;
                if (d >= CLR + N) begin
                    if (m_cnt == TOTAL) begin
                        m_in = 1'b0;
                        m_done = 1'b1;
                    end
`ifdef CONV1_CTRL_WDT_EN
                    else if (d - CLR - N == DMAX - 1) begin
                        m_in = 1'b0;
                        m_done = 1'b1;
                        m_err = 1'b1;
                    end
`endif
                end
            end
        end else if (!was_done && start) begin
            m_in = 1'b1;
            m_t0 = t + 1;
            m_cnt = 0;
            m_err = 1'b0;
            m_issued = 0;
            foreach (img[i]) img[i] = 1'($urandom);
        end
    endfunction

    task automatic check_outputs();
        int d;
        int e_busy, e_crst, e_rd, e_addr, e_pix;
        d = t - m_t0;
        if (m_in) begin
            e_busy = 1;
            e_crst = (d >= CLR) ? 1 : 0;
            e_rd   = (d >= CLR && d < CLR + N) ? 1 : 0;
            e_addr = (e_rd == 1) ? d - CLR : 0;
            e_pix  = (d > CLR && d <= CLR + N) ? int'(img[d - CLR - 1]) : 0;
        end else begin
            e_busy = 0;
            e_crst = m_flush ? 0 : 1;
            e_rd   = 0;
            e_addr = 0;
            e_pix  = 0;
        end
        check("busy",      32'(busy),       e_busy);
        check("conv_rstn", 32'(conv_rst_n), e_crst);
        check("mem_rd",    32'(mem_rd),     e_rd);
        check("mem_addr",  32'(mem_addr),   e_addr);
        check("pixel",     32'(pixel_out),  e_pix);
        check("done",      32'(done),       32'(m_done));
        check("out_count", 32'(out_count),  m_cnt);
        check("err",       32'(err),        32'(m_err));
    endtask

    task automatic gen_valid();
        int d;
        d = t - m_t0;
        case (mode)
            0: conv_valid = 1'($urandom);
            1: conv_valid = !m_in || (d >= CLR + N - 1);
            2: conv_valid = m_in && (d >= CLR);
            default: begin
                conv_valid = m_in && (d >= CLR) && (m_issued < 600);
                if (conv_valid) m_issued++;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        t++;
        #1;
        start = 1'b0;
        abort = 1'b0;
        mem_rdata = rd_q ? img[addr_q] : 1'($urandom);
        @(negedge clk);
        check_outputs();
        rd_q = mem_rd;
        addr_q = int'(mem_addr);
        gen_valid();
        if (m_in && $urandom_range(0, 199) == 0) start = 1'b1;
    endtask

    task automatic run_frame();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!m_done && k < 20000);
        check("frame_end", 32'(m_done), 1);
    endtask

    task automatic wait_addr(input int a);
        int k;
        k = 0;
        while (!(m_in && (t - m_t0) == CLR + a) && k < 3000) begin
            tick();
            k++;
        end
        check("reach_addr", 32'(mem_addr), a);
    endtask

    // Called at a falling edge: reset lands between clock edges.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",  32'(busy),       0);
        check("rst_rd",    32'(mem_rd),     0);
        check("rst_addr",  32'(mem_addr),   0);
        check("rst_crst",  32'(conv_rst_n), 0);
        check("rst_pix",   32'(pixel_out),  0);
        check("rst_done",  32'(done),       0);
        check("rst_count", 32'(out_count),  0);
        check("rst_err",   32'(err),        0);
        m_in = 1'b0;
        m_flush = 1'b1;
        m_done = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
        rd_q = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        t += 2;
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout cycle=%0d", t);
        $fatal(1, "bench timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();

        // Nominal frame, random conv1 valids.
        mode = 0;
        start = 1'b1;
        run_frame();

        // Start in the done cycle is dropped, the next one is taken.
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b1;
        run_frame();
        repeat (5) tick();

        // Saturating count; lone start in the done cycle.
        mode = 2;
        start = 1'b1;
        run_frame();
        start = 1'b1;
        repeat (6) tick();

        // Abort mid-stream, then a clean frame.
        mode = 0;
        start = 1'b1;
        wait_addr(300);
        abort = 1'b1;
        repeat (4) tick();
        abort = 1'b1;
        tick();
        start = 1'b1;
        run_frame();

        // Abort during the clear phase.
        start = 1'b1;
        tick();
        tick();
        abort = 1'b1;
        repeat (3) tick();

        // Asynchronous reset mid-stream.
        start = 1'b1;
        wait_addr(100 + $urandom_range(0, 400));
        async_reset();
        start = 1'b1;
        run_frame();

        for (int k = 0; k < 4; k++) begin
            tick();
            mode = $urandom_range(0, 2);
            start = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                wait_addr($urandom_range(0, N - 1));
                abort = 1'b1;
                repeat (2) tick();
            end else begin
                run_frame();
            end
        end

`ifdef CONV1_CTRL_WDT_EN
        tick();
        mode = 3;
        start = 1'b1;
        run_frame();
        tick();
        mode = 0;
        start = 1'b1;
        run_frame();
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
